// File: rtl/crossing_timer.sv
`default_nettype none
// ============================================================================
//  Module      : crossing_timer
//  Description : Interval timer feeding the crossing control unit. A tr pulse
//                starts an interval of (multiplier+1)*BASE_CYCLES clocks; at
//                expiry a one-cycle proceed pulse advances the phase. hold
//                freezes the countdown while an interval is running.
//  Revision    : 1.0 - initial release
// ============================================================================
module crossing_timer #(
    parameter int BASE_CYCLES = 10,
    parameter int CNT_W       = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tr,
    input  logic [1:0] multiplier,
    input  logic       hold,
    output logic       proceed,
    output logic       busy,
    output logic [1:0] units_left
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Prescaler reload value: one time unit spans BASE_CYCLES edges
    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(BASE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_presc_next;
    logic [1:0]       r_units;
    logic [1:0]       w_units_next;
    logic             r_proceed;
    logic             w_proceed_next;

    // State, counters and the expiry pulse register; reset aborts any interval
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_units   <= '0;
            r_proceed <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_presc   <= w_presc_next;
            r_units   <= w_units_next;
            r_proceed <= w_proceed_next;
        end
    end

    // Next-state logic: restart has top priority, then countdown unless held
    always_comb begin
        w_state_next   = r_state;
        w_presc_next   = r_presc;
        w_units_next   = r_units;
        w_proceed_next = 1'b0;

        if (tr) begin
            // Restart discards any running interval without a pulse
            w_state_next = S_RUN;
            w_presc_next = c_RELOAD;
            w_units_next = multiplier;
        end else if (r_state == S_RUN && !hold) begin
            if (r_presc != '0) begin
                w_presc_next = r_presc - CNT_W'(1);
            end else if (r_units != 2'd0) begin
                // Unit boundary with whole units still pending
                w_presc_next = c_RELOAD;
                w_units_next = r_units - 2'd1;
            end else begin
                // Last unit consumed: signal expiry and go idle
                w_state_next   = S_IDLE;
                w_proceed_next = 1'b1;
            end
        end
    end

    assign proceed    = r_proceed;
    assign busy       = (r_state == S_RUN);
    assign units_left = r_units;

endmodule
`default_nettype wire

// File: tb/tb_crossing_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossing_timer
//  Description : Self-checking bench for crossing_timer. Two instances
//                (BASE_CYCLES=4 and BASE_CYCLES=1) share stimulus and are
//                compared every cycle against a remaining-cycles model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crossing_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tr;
    logic [1:0] multiplier;
    logic       hold;
    logic       p4, b4, p1, b1;
    logic [1:0] u4, u1;

    int tests = 0;
    int fails = 0;

    crossing_timer #(.BASE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .tr(tr), .multiplier(multiplier), .hold(hold),
        .proceed(p4), .busy(b4), .units_left(u4)
    );

    crossing_timer #(.BASE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .tr(tr), .multiplier(multiplier), .hold(hold),
        .proceed(p1), .busy(b1), .units_left(u1)
    );

    always #5 clk = ~clk;

    // Model: per instance, number of un-held RUN edges left before expiry
    int mb   [2] = '{4, 1};
    int mrem [2] = '{0, 0};
    bit mbusy[2] = '{0, 0};
    bit mpro [2] = '{0, 0};
    bit started = 0;

    // Model update on every rising edge from the sampled inputs
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                mbusy[i] <= 0; mrem[i] <= 0; mpro[i] <= 0;
            end else if (tr) begin
                mbusy[i] <= 1; mrem[i] <= (int'(multiplier) + 1) * mb[i]; mpro[i] <= 0;
            end else if (mbusy[i] && !hold) begin
                if (mrem[i] == 1) begin
                    mbusy[i] <= 0; mrem[i] <= 0; mpro[i] <= 1;
                end else begin
                    mrem[i] <= mrem[i] - 1; mpro[i] <= 0;
                end
            end else begin
                mpro[i] <= 0;
            end
        end
        if (!reset) started <= 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_units(input int i);
        return mbusy[i] ? (mrem[i] - 1) / mb[i] : 0;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            check("b4_proceed", int'(p4), int'(mpro[0]));
            check("b4_busy",    int'(b4), int'(mbusy[0]));
            check("b4_units",   int'(u4), exp_units(0));
            check("b1_proceed", int'(p1), int'(mpro[1]));
            check("b1_busy",    int'(b1), int'(mbusy[1]));
            check("b1_units",   int'(u1), exp_units(1));
        end
    end

    // Start an interval at edge E0, optionally hold / retrigger, and measure
    // the edge index (relative to E0) of the first proceed on each instance
    task automatic measure(input string name, input int m, input int hs, input int hl,
                           input int rt, input int rm, input int exp4, input int exp1);
        int lat4 = -1;
        int lat1 = -1;
        @(posedge clk); #1;
        tr = 1; multiplier = 2'(m); hold = 0;
        @(posedge clk); #1;
        tr = 0;
        for (int k = 1; k <= 100 && (lat4 < 0 || lat1 < 0); k++) begin
            hold       = (k >= hs && k < hs + hl);
            tr         = (k == rt);
            multiplier = (k == rt) ? 2'(rm) : 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            if (lat4 < 0 && p4) lat4 = k;
            if (lat1 < 0 && p1) lat1 = k;
        end
        tr = 0; hold = 0;
        check({name, "_lat_base4"}, lat4, exp4);
        check({name, "_lat_base1"}, lat1, exp1);
        repeat (20) @(posedge clk);
        #1;
    endtask

    int pm[3] = '{1, 0, 3};
    int sp[3] = '{10, 6, 18};

    initial begin
        reset = 0; tr = 1; multiplier = 2'd3; hold = 1;

        // Reset dominates tr and hold
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("rst_proceed", int'(p4), 0);
            check("rst_busy",    int'(b4), 0);
            check("rst_units",   int'(u4), 0);
        end
        reset = 1; tr = 0; hold = 0;
        repeat (3) @(posedge clk);
        #1;

        // Directed latencies (hand-computed)
        measure("m1",        1, 0, 0, 0, 0,  8, 2);
        measure("m3",        3, 0, 0, 0, 0, 16, 4);
        measure("m0",        0, 0, 0, 0, 0,  4, 1);
        measure("hold5",     1, 2, 5, 0, 0, 13, 7);
        measure("retrig",    1, 0, 0, 6, 3, 22, 2);
        measure("tr_expiry", 0, 0, 0, 4, 0,  8, 1);

        // Randomized traffic including occasional reset and hold
        for (int c = 0; c < 1500; c++) begin
            reset      = ($urandom_range(0, 63) != 0);
            tr         = ($urandom_range(0, 11) == 0);
            multiplier = 2'($urandom_range(0, 3));
            hold       = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end

        // Closed loop with a behavioural control unit released with this block
        reset = 0; tr = 1; hold = 0; multiplier = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        begin
            int cur = 0;
            int tr_edge = 1;
            int nprev = -1;
            int npro = 0;
            for (int k = 1; k <= 400 && npro < 7; k++) begin
                tr         = (k == tr_edge);
                multiplier = (k == tr_edge) ? 2'(pm[cur]) : 2'($urandom_range(0, 3));
                @(posedge clk); #1;
                if (p4) begin
                    if (nprev < 0) check("loop_first_green", k, 9);
                    else check($sformatf("loop_spacing_phase%0d", cur), k - nprev, sp[cur]);
                    nprev   = k;
                    npro++;
                    cur     = (cur + 1) % 3;
                    tr_edge = k + 2;
                end
            end
            tr = 0;
            check("loop_proceed_count", npro, 7);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
